vector_scalar_op: RTL

//  Applies one scalar to every element of an N-element floating-point vector: ADD, SUB, RSUB or MUL, selected per transaction.

---
 rtl/precision_pkg.sv | 25 ++
 rtl/vector_scalar_lane.sv | 170 +++++++++++++++++
 rtl/vector_scalar_op.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/precision_pkg.sv
// Shared types and helpers for the Precision library.
//   vs_op_t    : scalar operation selected per vector transaction
//   vs_state_t : vector_scalar_op control states
//   ceil_div   : integer ceiling division used to size beat counts
package precision_pkg;

    typedef enum logic [1:0] {
        VS_ADD  = 2'd0,
        VS_SUB  = 2'd1,
        VS_RSUB = 2'd2,
        VS_MUL  = 2'd3
    } vs_op_t;

    typedef enum logic [1:0] {
        VS_IDLE  = 2'd0,
        VS_ISSUE = 2'd1,
        VS_DRAIN = 2'd2,
        VS_DONE  = 2'd3
    } vs_state_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/vector_scalar_lane.sv
// One arithmetic lane of vector_scalar_op: one element in, one result out.
// Evaluates add / subtract / multiply on the selected op and delays the result
// through an OP_LATENCY-deep valid/data pipeline so every op has the same
// issue-to-result latency. Subnormal inputs and results flush to zero; rounding
// is round-to-nearest-even; NaN results are the canonical quiet NaN.
// Ports:
//   clk, rstn       clock, asynchronous active-low reset (clears the pipeline)
//   in_valid        operands valid this cycle
//   op              vs_op_t encoding (RSUB computes b - a)
//   a, b            operands
//   out_valid, c    result valid / result, OP_LATENCY cycles after issue
module vector_scalar_lane
    import precision_pkg::*;
#(
    parameter int    BITS       = 16,
    parameter string PRECISION  = "HALF",
    parameter int    OP_LATENCY = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    input  logic [1:0]      op,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    output logic            out_valid,
    output logic [BITS-1:0] c
);

    localparam int EW   = (PRECISION == "DOUBLE") ? 11 : (PRECISION == "SINGLE") ? 8 : 5;
    localparam int MW   = BITS - 1 - EW;
    localparam int BIAS = (1 << (EW - 1)) - 1;
    localparam int EMAX = (1 << EW) - 1;
    localparam int RW   = MW + 4;  // hidden bit + fraction + guard/round/sticky

    localparam logic [BITS-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

    function automatic logic is_zero(input logic [BITS-1:0] v);
        return ~|v[BITS-2:MW];
    endfunction

    function automatic logic is_inf(input logic [BITS-1:0] v);
        return (&v[BITS-2:MW]) && ~|v[MW-1:0];
    endfunction

    function automatic logic is_nan(input logic [BITS-1:0] v);
        return (&v[BITS-2:MW]) && |v[MW-1:0];
    endfunction

    // m[RW-1] is the leading one; m[2:0] are guard, round, sticky.
    function automatic logic [BITS-1:0] round_pack(input logic s, input int e,
                                                   input logic [RW-1:0] m);
        logic [MW+1:0] rnd;
        logic          up;
        int            er;
        up  = m[2] && (m[1] || m[0] || m[3]);
        rnd = {1'b0, m[RW-1:3]} + {{(MW+1){1'b0}}, up};
        er  = e;
        if (rnd[MW+1]) begin
            er  = er + 1;
            rnd = rnd >> 1;
        end
        if (er >= EMAX) return {s, {EW{1'b1}}, {MW{1'b0}}};
        if (er <= 0) return {s, {(BITS-1){1'b0}}};
        return {s, er[EW-1:0], rnd[MW-1:0]};
    endfunction

    function automatic logic [BITS-1:0] fp_add(input logic [BITS-1:0] x, input logic [BITS-1:0] y);
        logic [BITS-1:0] big, sml;
        logic [RW-1:0]   mb, ms, mask;
        logic [RW:0]     sum;
        logic            stk;
        int              d, e, lz;
        if (is_nan(x) || is_nan(y)) return QNAN;
        if (is_inf(x) && is_inf(y)) return (x[BITS-1] != y[BITS-1]) ? QNAN : x;
        if (is_inf(x)) return x;
        if (is_inf(y)) return y;
        if (is_zero(x)) return is_zero(y) ? {x[BITS-1] & y[BITS-1], {(BITS-1){1'b0}}} : y;
        if (is_zero(y)) return x;
        if (x[BITS-2:0] >= y[BITS-2:0]) begin
            big = x;
            sml = y;
        end else begin
            big = y;
            sml = x;
        end
        mb = {1'b1, big[MW-1:0], 3'b000};
        ms = {1'b1, sml[MW-1:0], 3'b000};
        e  = int'(big[BITS-2:MW]);
        d  = e - int'(sml[BITS-2:MW]);
        if (d >= RW) begin
            stk = 1'b1;
            ms  = '0;
        end else begin
            mask = (RW'(1) << d) - RW'(1);
            stk  = |(ms & mask);
            ms   = ms >> d;
        end
        ms[0] = ms[0] | stk;
        if (big[BITS-1] == sml[BITS-1]) begin
            sum = {1'b0, mb} + {1'b0, ms};
            if (sum[RW]) begin
                e   = e + 1;
                sum = {1'b0, sum[RW:2], sum[1] | sum[0]};
            end
        end else begin
            // Magnitudes are ordered, so the difference is never negative.
            sum = {1'b0, mb} - {1'b0, ms};
            if (sum == '0) return '0;
            lz = 0;
            for (int i = 0; i < RW; i++) begin
                if (sum[i]) lz = RW - 1 - i;
            end
            sum = sum << lz;
            e   = e - lz;
        end
        return round_pack(big[BITS-1], e, sum[RW-1:0]);
    endfunction

    function automatic logic [BITS-1:0] fp_mul(input logic [BITS-1:0] x, input logic [BITS-1:0] y);
        logic [2*MW+1:0] p;
        logic            s;
        int              e;
        s = x[BITS-1] ^ y[BITS-1];
        if (is_nan(x) || is_nan(y)) return QNAN;
        if (is_inf(x) || is_inf(y))
            return (is_zero(x) || is_zero(y)) ? QNAN : {s, {EW{1'b1}}, {MW{1'b0}}};
        if (is_zero(x) || is_zero(y)) return {s, {(BITS-1){1'b0}}};
        p = {1'b1, x[MW-1:0]} * {1'b1, y[MW-1:0]};
        e = int'(x[BITS-2:MW]) + int'(y[BITS-2:MW]) - BIAS;
        if (p[2*MW+1]) e = e + 1;
        else p = p << 1;
        return round_pack(s, e, {p[2*MW+1:MW-1], |p[MW-2:0]});
    endfunction

    logic [BITS-1:0] res;

    always_comb begin
        res = '0;
        unique case (vs_op_t'(op))
            VS_ADD:  res = fp_add(a, b);
            VS_SUB:  res = fp_add(a, {~b[BITS-1], b[BITS-2:0]});
            VS_RSUB: res = fp_add(b, {~a[BITS-1], a[BITS-2:0]});
            VS_MUL:  res = fp_mul(a, b);
            default: res = '0;
        endcase
    end

    logic            vld_q [OP_LATENCY];
    logic [BITS-1:0] dat_q [OP_LATENCY];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < OP_LATENCY; i++) begin
                vld_q[i] <= 1'b0;
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_valid;
            dat_q[0] <= res;
            for (int i = 1; i < OP_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[OP_LATENCY-1];
    assign c         = dat_q[OP_LATENCY-1];

endmodule

// File: rtl/vector_scalar_op.sv
// Applies one scalar to every element of an N-element float vector
// (ADD a+b, SUB a-b, RSUB b-a, MUL a*b), time-multiplexing the elements over
// LANES pipelined lanes in BEATS = ceil(N/LANES) issue beats.
// Handshakes: a transfer happens on a side in any cycle where valid && ready.
// The source holds in_valid/op/a/b until in_ready; the block holds out_valid/c
// until out_ready. in_ready is high only in IDLE and out_valid only in DONE, so
// transactions never overlap.
// Ports:
//   clk, rstn              clock, asynchronous active-low reset
//   in_valid, in_ready     input handshake for op, a[N], b
//   out_valid, out_ready   output handshake for c[N]
//   dbg_state              current vs_state_t
//   perf_ops, perf_stall   only with VECTOR_SCALAR_OP_PERF_EN: completed
//                          transactions and DONE cycles with out_ready low
module vector_scalar_op
    import precision_pkg::*;
#(
    parameter int    BITS       = 16,
    parameter string PRECISION  = "HALF",
    parameter int    N          = 3,
    parameter int    LANES      = 1,
    parameter int    OP_LATENCY = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [BITS-1:0] a [N],
    input  logic [BITS-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] c [N],
    output logic [1:0]      dbg_state
`ifdef VECTOR_SCALAR_OP_PERF_EN
    ,
    output logic [31:0]     perf_ops,
    output logic [31:0]     perf_stall
`endif
);

    localparam int BEATS = ceil_div(N, LANES);
    localparam int CW    = $clog2(BEATS + 1);

    vs_state_t       state;
    vs_op_t          op_q;
    logic [BITS-1:0] a_q [N];
    logic [BITS-1:0] b_q;
    logic [CW-1:0]   beat_cnt;
    logic [CW-1:0]   ret_cnt;
    logic [BITS-1:0] lane_a [LANES];
    logic [BITS-1:0] lane_b [LANES];
    logic [BITS-1:0] lane_c [LANES];
    logic [LANES-1:0] lane_vld;
    logic            ret_fire;
    logic            unused_lane_vld;

    assign in_ready  = (state == VS_IDLE);
    assign out_valid = (state == VS_DONE);
    assign dbg_state = state;

    // Beat k feeds elements k*LANES+i; lanes past the end of the vector get 0.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_a[i] = '0;
            lane_b[i] = '0;
            for (int e = 0; e < N; e++) begin
                if (e == int'(beat_cnt) * LANES + i) begin
                    lane_a[i] = a_q[e];
                    lane_b[i] = b_q;
                end
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        vector_scalar_lane #(
            .BITS       (BITS),
            .PRECISION  (PRECISION),
            .OP_LATENCY (OP_LATENCY)
        ) u_lane (
            .clk       (clk),
            .rstn      (rstn),
            .in_valid  (state == VS_ISSUE),
            .op        (op_q),
            .a         (lane_a[i]),
            .b         (lane_b[i]),
            .out_valid (lane_vld[i]),
            .c         (lane_c[i])
        );
    end

    // All lanes run in lock-step, so lane 0 alone paces the return side.
    assign ret_fire        = lane_vld[0] && ((state == VS_ISSUE) || (state == VS_DRAIN))
                             && (int'(ret_cnt) < BEATS);
    assign unused_lane_vld = ^lane_vld;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= VS_IDLE;
            op_q     <= VS_ADD;
            b_q      <= '0;
            beat_cnt <= '0;
            ret_cnt  <= '0;
            for (int e = 0; e < N; e++) begin
                a_q[e] <= '0;
                c[e]   <= '0;
            end
        end else begin
            if (ret_fire) begin
                for (int i = 0; i < LANES; i++) begin
                    for (int e = 0; e < N; e++) begin
                        if (e == int'(ret_cnt) * LANES + i) c[e] <= lane_c[i];
                    end
                end
                ret_cnt <= ret_cnt + 1'b1;
            end
            case (state)
                VS_IDLE: begin
                    if (in_valid) begin
                        op_q     <= vs_op_t'(op);
                        a_q      <= a;
                        b_q      <= b;
                        beat_cnt <= '0;
                        ret_cnt  <= '0;
                        state    <= VS_ISSUE;
                    end
                end
                VS_ISSUE: begin
                    if (beat_cnt == CW'(BEATS - 1)) begin
                        beat_cnt <= '0;
                        state    <= VS_DRAIN;
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                VS_DRAIN: begin
                    // One cycle after the final result lands in c.
                    if (ret_cnt == CW'(BEATS)) state <= VS_DONE;
                end
                VS_DONE: begin
                    if (out_ready) begin
                        ret_cnt <= '0;
                        state   <= VS_IDLE;
                    end
                end
                default: state <= VS_IDLE;
            endcase
        end
    end

`ifdef VECTOR_SCALAR_OP_PERF_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_ops   <= '0;
            perf_stall <= '0;
        end else if (state == VS_DONE) begin
            if (out_ready) perf_ops <= perf_ops + 32'd1;
            else           perf_stall <= perf_stall + 32'd1;
        end
    end
`else
    // No performance counters in this build.
`endif

endmodule
